// File: rtl/cbus_ram_responder.sv
// cbus_ram_responder: CBus memory responder serving single/burst transfers from a 64-bit word array
package cbus_pkg;
    typedef enum logic {BURST_FIXED = 1'b0, BURST_INCR = 1'b1} cbus_burst_t;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;
        cbus_burst_t burst;
    } cbus_req_t;
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_ram_responder
    import cbus_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  req,
    output cbus_resp_t resp,
    output logic       busy
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] WLOAD = LATENCY > 0 ? 4'(LATENCY - 1) : 4'd0;
    typedef enum logic [1:0] {IDLE, WAIT, XFER, COOL} state_t;
    state_t state, state_n;
    logic [AW-1:0] ptr, ptr_n;
    logic [3:0] cnt, cnt_n, wcnt, wcnt_n;
    logic is_wr, is_wr_n, incr, incr_n, inr, inr_n;
    logic [63:0] off;
    logic [63:0] mem [MEM_WORDS];
    logic rdy, we, unused;
    assign off = req.addr - BASE_ADDR;
    assign rdy = state == XFER;
    assign we = rdy && is_wr && inr && req.valid;
    assign busy = state != IDLE;
    assign resp = '{rdy, rdy && cnt == 4'd0, (rdy && !is_wr && inr) ? mem[ptr] : 64'd0};
    assign unused = &{1'b0, req.size};
    // next-state logic: accept in IDLE, count latency in WAIT, one beat per cycle in XFER
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        cnt_n = cnt;
        wcnt_n = wcnt;
        is_wr_n = is_wr;
        incr_n = incr;
        inr_n = inr;
        case (state)
            IDLE: if (req.valid) begin
                is_wr_n = req.is_write;
                incr_n = req.burst == BURST_INCR;
                ptr_n = off[AW+2:3];
                inr_n = req.addr >= BASE_ADDR && off < (64'(MEM_WORDS) << 3);
                cnt_n = req.len;
                wcnt_n = WLOAD;
                state_n = LATENCY > 0 ? WAIT : XFER;
            end
            WAIT: begin
                wcnt_n = wcnt == 4'd0 ? 4'd0 : wcnt - 4'd1;
                state_n = !req.valid ? IDLE : wcnt == 4'd0 ? XFER : WAIT;
            end
            XFER: if (!req.valid) state_n = IDLE;
            else begin
                state_n = cnt == 4'd0 ? COOL : XFER;
                cnt_n = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
                ptr_n = incr ? ptr + 1'b1 : ptr;
            end
            default: state_n = IDLE;
        endcase
    end
    // state and transfer registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr <= '0;
            cnt <= '0;
            wcnt <= '0;
            is_wr <= 1'b0;
            incr <= 1'b0;
            inr <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            cnt <= cnt_n;
            wcnt <= wcnt_n;
            is_wr <= is_wr_n;
            incr <= incr_n;
            inr <= inr_n;
        end
    end
    // byte-strobed write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 8; i++)
                if (req.strobe[i]) mem[ptr][8*i +: 8] <= req.data[8*i +: 8];
    end
endmodule

// File: tb/tb_cbus_ram_responder.sv
// tb_cbus_ram_responder: directed table-driven bench for the CBus RAM responder
module tb_cbus_ram_responder;
    import cbus_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    cbus_req_t req;
    cbus_resp_t resp;
    logic busy;
    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] bd [16];
    logic bl [16];
    int bk [16];
    int nb;

    typedef struct {
        logic        wr;
        logic [63:0] a;
        logic [7:0]  st;
        logic [63:0] d;
        logic [63:0] e;
    } vec_t;
    vec_t tbl [$];

    cbus_ram_responder dut (.clk(clk), .reset(reset), .req(req), .resp(resp), .busy(busy));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input logic wr, input logic [63:0] a, input logic [3:0] ln, input logic bu,
                       input logic [7:0] st, input logic [63:0] d0, input logic [63:0] ds,
                       input bit hold, input int rst_at);
        bit done = 0;
        @(negedge clk);
        req.valid = 1'b1;
        req.is_write = wr;
        req.size = 3'd3;
        req.addr = a;
        req.strobe = st;
        req.data = d0;
        req.len = ln;
        req.burst = cbus_burst_t'(bu);
        @(posedge clk);
        nb = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (resp.ready && nb < 16) begin
                bd[nb] = resp.data;
                bl[nb] = resp.last;
                bk[nb] = k;
                if (nb == rst_at) begin
                    reset = 1'b0;
                    #1;
                    chk("rst_ready", 64'(resp.ready), 0);
                    chk("rst_last", 64'(resp.last), 0);
                    chk("rst_data", resp.data, 0);
                    chk("rst_busy", 64'(busy), 0);
                    req.valid = 1'b0;
                    @(negedge clk);
                    reset = 1'b1;
                    nb++;
                    done = 1;
                    break;
                end
                nb++;
                if (resp.last) begin
                    done = 1;
                    break;
                end
            end
            @(posedge clk);
            #1;
            req.data = d0 + 64'(nb) * ds;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no last beat expected one within 40 cycles");
            req.valid = 1'b0;
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
        end else if (rst_at < 0 && !hold) begin
            @(negedge clk);
            req.valid = 1'b0;
        end
    endtask

    task automatic rd_chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        run(1'b0, a, 4'd0, 1'b1, 8'hFF, 64'd0, 64'd0, 1'b0, -1);
        chk(nm, bd[0], e);
    endtask

    initial begin
        logic [63:0] fx [4];
        req = '0;
        tbl.push_back('{1'b1, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 64'h0});
        tbl.push_back('{1'b0, 64'h8000_0010, 8'hFF, 64'h0, 64'h1122_3344_5566_7788});
        tbl.push_back('{1'b1, 64'h8000_0010, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        tbl.push_back('{1'b0, 64'h8000_0010, 8'hFF, 64'h0, 64'h1122_3344_FFFF_FFFF});
        tbl.push_back('{1'b1, 64'h8000_0000, 8'hFF, 64'hA0, 64'h0});
        tbl.push_back('{1'b1, 64'h8000_0008, 8'hFF, 64'hA1, 64'h0});
        tbl.push_back('{1'b1, 64'h8000_0010, 8'hFF, 64'hA2, 64'h0});
        tbl.push_back('{1'b1, 64'h8000_0018, 8'hFF, 64'hA3, 64'h0});
        tbl.push_back('{1'b0, 64'h8000_0017, 8'hFF, 64'h0, 64'hA2});
        tbl.push_back('{1'b1, 64'h8000_0028, 8'hFF, 64'h55, 64'h0});
        tbl.push_back('{1'b1, 64'h8000_0030, 8'hFF, 64'h66, 64'h0});
        tbl.push_back('{1'b1, 64'h8000_0038, 8'hFF, 64'h77, 64'h0});
        tbl.push_back('{1'b1, 64'h8000_0040, 8'hFF, 64'h88, 64'h0});
        tbl.push_back('{1'b1, 64'h8000_0080, 8'hFF, 64'h1616, 64'h0});
        tbl.push_back('{1'b1, 64'h8000_0088, 8'hFF, 64'h1717, 64'h0});
        tbl.push_back('{1'b1, 64'h8000_7FF8, 8'hFF, 64'hEE, 64'h0});
        tbl.push_back('{1'b0, 64'h7FFF_FFF8, 8'hFF, 64'h0, 64'h0});
        tbl.push_back('{1'b1, 64'h7FFF_FFF8, 8'hFF, 64'hDEAD, 64'h0});
        tbl.push_back('{1'b0, 64'h8000_8000, 8'hFF, 64'h0, 64'h0});
        tbl.push_back('{1'b1, 64'h8000_8000, 8'hFF, 64'hBAD, 64'h0});
        tbl.push_back('{1'b0, 64'h8000_7FF8, 8'hFF, 64'h0, 64'hEE});
        tbl.push_back('{1'b0, 64'h8000_0000, 8'hFF, 64'h0, 64'hA0});
        #1;
        chk("reset_ready", 64'(resp.ready), 0);
        chk("reset_last", 64'(resp.last), 0);
        chk("reset_data", resp.data, 0);
        chk("reset_busy", 64'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        foreach (tbl[i]) begin
            run(tbl[i].wr, tbl[i].a, 4'd0, 1'b1, tbl[i].st, tbl[i].d, 64'd0, 1'b0, -1);
            chk($sformatf("v%0d_lat", i), 64'(bk[0]), 3);
            chk($sformatf("v%0d_last", i), 64'(bl[0]), 1);
            chk($sformatf("v%0d_beats", i), 64'(nb), 1);
            if (!tbl[i].wr) chk($sformatf("v%0d_data", i), bd[0], tbl[i].e);
        end
        run(1'b0, 64'h8000_0000, 4'd3, 1'b1, 8'hFF, 64'd0, 64'd0, 1'b0, -1);
        chk("incr_beats", 64'(nb), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("incr_data%0d", i), bd[i], 64'hA0 + 64'(i));
            chk($sformatf("incr_cyc%0d", i), 64'(bk[i]), 64'(3 + i));
            chk($sformatf("incr_last%0d", i), 64'(bl[i]), 64'(i == 3));
        end
        run(1'b1, 64'h8000_0028, 4'd3, 1'b0, 8'hFF, 64'd1, 64'd1, 1'b0, -1);
        chk("fixed_beats", 64'(nb), 4);
        chk("fixed_lastcyc", 64'(bk[3]), 6);
        fx[0] = 64'h4;
        fx[1] = 64'h66;
        fx[2] = 64'h77;
        fx[3] = 64'h88;
        for (int i = 0; i < 4; i++)
            rd_chk($sformatf("fixed_word%0d", 5 + i), 64'h8000_0028 + 64'(8 * i), fx[i]);
        run(1'b0, 64'h8000_7FF8, 4'd1, 1'b1, 8'hFF, 64'd0, 64'd0, 1'b0, -1);
        chk("wrap_d0", bd[0], 64'hEE);
        chk("wrap_d1", bd[1], 64'hA0);
        chk("wrap_last0", 64'(bl[0]), 0);
        chk("wrap_last1", 64'(bl[1]), 1);
        run(1'b1, 64'h8000_0080, 4'd7, 1'b1, 8'hFF, 64'h100, 64'd1, 1'b0, 1);
        chk("rst_beats", 64'(nb), 2);
        rd_chk("rst_word16", 64'h8000_0080, 64'h100);
        rd_chk("rst_word17", 64'h8000_0088, 64'h1717);
        run(1'b0, 64'h8000_0008, 4'd0, 1'b1, 8'hFF, 64'd0, 64'd0, 1'b1, -1);
        chk("hold_data", bd[0], 64'hA1);
        @(negedge clk);
        chk("hold_cool_busy", 64'(busy), 1);
        chk("hold_cool_ready", 64'(resp.ready), 0);
        @(negedge clk);
        chk("hold_idle_busy", 64'(busy), 0);
        req.valid = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
